// File: rtl/rr_arb_pkg.sv
// Shared types and sizing for the 32-way round-robin arbiter.
// Optional grant timeout is enabled with the ARB_TIMEOUT_EN macro.
package rr_arb_pkg;

    localparam int IDX_W        = 5;
    localparam int NUM_REQ      = 32;
    localparam int MAX_HOLD_DEF = 16;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    typedef struct packed {
        logic found;
        idx_t idx;
    } search_t;

endpackage

// File: rtl/gnt_decoder_5x32.sv
// 5-to-32 index decoder with enable; drives the one-hot grant bus.
// Purely combinational, fed from registered state.
module gnt_decoder_5x32
    import rr_arb_pkg::*;
(
    input  idx_t               idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_5x32.sv
// Round-robin arbiter, 32 requesters, registered index grant.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_arbiter_5x32
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic               timeout
);

    if (NUM_REQ != (1 << IDX_W) || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_cfg_bad
        $error("rr_arbiter_5x32: illegal NUM_REQ/IDX_W/MAX_HOLD");
    end

    state_e             state_q, state_d;
    idx_t               idx_q, idx_d;
    idx_t               ptr_q, ptr_d;
    logic               search_en;
    logic [NUM_REQ-1:0] mask;
    search_t            srch;

    // Rotate so ptr lands on bit 0, then take the lowest set bit.
    function automatic search_t rr_search(
        input logic [NUM_REQ-1:0] r,
        input idx_t               p
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        search_t              s;
        dbl     = {r, r} >> p;
        rot     = dbl[NUM_REQ-1:0];
        s.found = |rot;
        s.idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                s.idx = p + idx_t'(i);
            end
        end
        return s;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        search_en = 1'b0;
        mask      = '1;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        tmo_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                search_en = 1'b1;
            end
            GRANT: begin
                search_en = !req[idx_q];
`ifdef ARB_TIMEOUT_EN
                hold_d = hold_q + 8'd1;
                // Forced release: current holder sits out this search.
                if (!search_en && hold_q == HOLD_LAST) begin
                    search_en = 1'b1;
                    tmo_d     = 1'b1;
                    mask      = ~gnt_onehot;
                end
`endif
            end
            default: ;
        endcase

        srch = rr_search(req & mask, ptr_q);

        if (search_en) begin
            if (srch.found) begin
                state_d = GRANT;
                idx_d   = srch.idx;
                ptr_d   = srch.idx + idx_t'(1);
`ifdef ARB_TIMEOUT_EN
                hold_d  = 8'd0;
`endif
            end else begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= 8'd0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    gnt_decoder_5x32 u_dec (
        .idx_i    (idx_q),
        .en_i     (gnt_valid),
        .onehot_o (gnt_onehot)
    );

endmodule

// File: tb/tb_rr_arbiter_5x32.sv
// Directed bench for rr_arbiter_5x32 with hand-computed grants.
// Timeout vectors run only when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_5x32;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_HOLD = 4;
`else
    localparam int TB_HOLD = 16;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic [31:0] gnt_onehot;
    logic        timeout;

    int total;
    int bad;

    rr_arbiter_5x32 #(.MAX_HOLD(TB_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_is(input string tag, input logic [4:0] idx);
        chk({tag, ".v"}, 32'(gnt_valid), 32'd1);
        chk({tag, ".i"}, 32'(gnt_idx), 32'(idx));
        chk({tag, ".oh"}, gnt_onehot, 32'd1 << idx);
    endtask

    task automatic idle_is(input string tag);
        chk({tag, ".v"}, 32'(gnt_valid), 32'd0);
        chk({tag, ".i"}, 32'(gnt_idx), 32'd0);
        chk({tag, ".oh"}, gnt_onehot, 32'd0);
    endtask

    task automatic rst_pulse();
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 32'hFFFF_FFFF;
        #3;
        idle_is("rst0");
        chk("rst0.to", 32'(timeout), 32'd0);
        step();
        step();
        idle_is("rst1");
        rst = 1'b0;
        step();
        grant_is("rel0", 5'd0);
        req = '0;
        step();
        idle_is("rel_drop");

        req = 32'h0000_0100;
        step();
        grant_is("single", 5'd8);
        step();
        grant_is("single_hold", 5'd8);
        req = '0;
        step();
        idle_is("single_drop");

        // rotation 0,2,31,0 from ptr=0
        rst_pulse();
        req = 32'h8000_0005;
        step();
        grant_is("rot0", 5'd0);
        step();
        grant_is("rot0h", 5'd0);
        req = 32'h8000_0004;
        step();
        grant_is("rot2", 5'd2);
        req = 32'h8000_0005;
        step();
        grant_is("rot2h", 5'd2);
        req = 32'h8000_0001;
        step();
        grant_is("rot31", 5'd31);
        req = 32'h8000_0005;
        step();
        grant_is("rot31h", 5'd31);
        req = 32'h0000_0005;
        step();
        grant_is("rot0b", 5'd0);

        // fairness: 4 releases and re-requests behind 9 and 3
        req = 32'h0000_0008;
        step();
        grant_is("fair3", 5'd3);
        req = 32'h0000_0210;
        step();
        grant_is("fair4", 5'd4);
        req = 32'h0000_0208;
        step();
        grant_is("fair9", 5'd9);
        req = 32'h0000_0218;
        step();
        grant_is("fair9h", 5'd9);
        req = 32'h0000_0018;
        step();
        grant_is("fair3b", 5'd3);
        req = 32'h0000_0010;
        step();
        grant_is("fair4b", 5'd4);
        req = '0;
        step();
        idle_is("fair_end");

        // mid-grant async reset
        req = 32'h0002_0000;
        step();
        grant_is("g17", 5'd17);
        rst = 1'b1;
        #1;
        idle_is("async_rst");
        #4;
        rst = 1'b0;
        req = 32'h0012_0000;
        step();
        grant_is("post_rst", 5'd17);

        // full rotation with single-cycle releases
        rst_pulse();
        req = 32'hFFFF_FFFF;
        step();
        chk("all.i0", 32'(gnt_idx), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            req = ~(32'd1 << (k - 1));
            step();
            chk("all.mv", 32'(gnt_idx), 32'(k % 32));
            req = 32'hFFFF_FFFF;
            step();
            chk("all.hold", 32'(gnt_idx), 32'(k % 32));
        end
        chk("all.v", 32'(gnt_valid), 32'd1);

`ifdef ARB_TIMEOUT_EN
        rst_pulse();
        req = 32'h0000_0060;
        step();
        grant_is("tmo5a", 5'd5);
        chk("tmo.a", 32'(timeout), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            grant_is("tmo5h", 5'd5);
            chk("tmo.h", 32'(timeout), 32'd0);
        end
        step();
        grant_is("tmo6", 5'd6);
        chk("tmo.p", 32'(timeout), 32'd1);
        step();
        grant_is("tmo6h", 5'd6);
        chk("tmo.z", 32'(timeout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
